// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register file.
// Holds start/end/count for each hardware loop. The CSR unit writes these
// registers and reads them back. The controller decrements the counts as
// loop iterations retire. The ID-stage PC is compared against each loop end
// so that fetch knows when to branch back to a loop start.
module riscv_hwloop_regs #(
  parameter int N_HWLP      = 2,
  parameter int N_HWLP_BITS = $clog2(N_HWLP)
) (
  input  logic                           clk,
  input  logic                           rst_n,

  input  logic [2:0]                     hwlp_we_i,
  input  logic [N_HWLP_BITS-1:0]         hwlp_regid_i,
  input  logic [31:0]                    hwlp_data_i,

  input  logic [N_HWLP-1:0]              hwlp_dec_cnt_i,

  input  logic [31:0]                    pc_id_i,

  output logic [N_HWLP-1:0][31:0]        hwlp_start_o,
  output logic [N_HWLP-1:0][31:0]        hwlp_end_o,
  output logic [N_HWLP-1:0][31:0]        hwlp_cnt_o,

  output logic [N_HWLP-1:0]              hwlp_match_o,
  output logic                           hwlp_jump_o,
  output logic [31:0]                    hwlp_target_o
);

  logic [N_HWLP-1:0][31:0] start_q;
  logic [N_HWLP-1:0][31:0] end_q;
  logic [N_HWLP-1:0][31:0] cnt_q;

  // Per-loop write selects. An out-of-range regid matches no loop, so the
  // write is dropped.
  logic [N_HWLP-1:0]       sel;
  logic [N_HWLP-1:0]       start_we;
  logic [N_HWLP-1:0]       end_we;
  logic [N_HWLP-1:0]       cnt_we;

  // Decrement requests that can take effect. A count write to the same
  // loop overrides the decrement. A count of zero stays at zero.
  logic [N_HWLP-1:0]       cnt_dec;

  // Loops whose end address is in ID and that still have at least two
  // iterations left. These loops must branch back to their start.
  logic [N_HWLP-1:0]       jump_cand;

  // Decode the register index and the write enables into per-loop strobes.
  always_comb begin
    sel      = '0;
    start_we = '0;
    end_we   = '0;
    cnt_we   = '0;
    cnt_dec  = '0;
    for (int i = 0; i < N_HWLP; i++) begin
      sel[i]      = (hwlp_regid_i == N_HWLP_BITS'(i));
      start_we[i] = sel[i] & hwlp_we_i[0];
      end_we[i]   = sel[i] & hwlp_we_i[1];
      cnt_we[i]   = sel[i] & hwlp_we_i[2];
      cnt_dec[i]  = hwlp_dec_cnt_i[i] & ~cnt_we[i] & (cnt_q[i] != 32'd0);
    end
  end

  // Start address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
    end else begin
      for (int i = 0; i < N_HWLP; i++) begin
        if (start_we[i]) begin
          start_q[i] <= hwlp_data_i;
        end
      end
    end
  end

  // End address registers. Each holds the address of the last body instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      end_q <= '0;
    end else begin
      for (int i = 0; i < N_HWLP; i++) begin
        if (end_we[i]) begin
          end_q[i] <= hwlp_data_i;
        end
      end
    end
  end

  // Iteration counters. A CSR write wins over a decrement, and a decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_HWLP; i++) begin
        if (cnt_we[i]) begin
          cnt_q[i] <= hwlp_data_i;
        end else if (cnt_dec[i]) begin
          cnt_q[i] <= cnt_q[i] - 32'd1;
        end
      end
    end
  end

  // Match the ID-stage PC against the loop ends using registered state only.
  always_comb begin
    hwlp_match_o = '0;
    jump_cand    = '0;
    for (int i = 0; i < N_HWLP; i++) begin
      hwlp_match_o[i] = (pc_id_i == end_q[i]) && (cnt_q[i] != 32'd0);
      jump_cand[i]    = hwlp_match_o[i] && (cnt_q[i] > 32'd1);
    end
  end

  // Select the jump target. The lowest-index candidate wins, so the inner
  // loop takes precedence when loops are nested.
  always_comb begin
    hwlp_target_o = '0;
    for (int i = N_HWLP - 1; i >= 0; i--) begin
      if (jump_cand[i]) begin
        hwlp_target_o = start_q[i];
      end
    end
  end

  assign hwlp_jump_o  = |jump_cand;
  assign hwlp_start_o = start_q;
  assign hwlp_end_o   = end_q;
  assign hwlp_cnt_o   = cnt_q;

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Self-checking bench for riscv_hwloop_regs. It runs directed scenarios and
// then randomised traffic. All outputs are compared against a behavioural
// model of the loop registers. Three loops are used so that an out-of-range
// regid can be driven.
module tb_riscv_hwloop_regs;

  localparam int N    = 3;
  localparam int NB   = $clog2(N);

  logic               clk;
  logic               rst_n;
  logic [2:0]         hwlp_we;
  logic [NB-1:0]      hwlp_regid;
  logic [31:0]        hwlp_data;
  logic [N-1:0]       hwlp_dec_cnt;
  logic [31:0]        pc_id;
  logic [N-1:0][31:0] hwlp_start;
  logic [N-1:0][31:0] hwlp_end;
  logic [N-1:0][31:0] hwlp_cnt;
  logic [N-1:0]       hwlp_match;
  logic               hwlp_jump;
  logic [31:0]        hwlp_target;

  int n_compared;
  int n_mismatched;

  // Reference model state
  logic [31:0] m_start [N];
  logic [31:0] m_end   [N];
  logic [31:0] m_cnt   [N];

  riscv_hwloop_regs #(.N_HWLP(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hwlp_we_i      (hwlp_we),
    .hwlp_regid_i   (hwlp_regid),
    .hwlp_data_i    (hwlp_data),
    .hwlp_dec_cnt_i (hwlp_dec_cnt),
    .pc_id_i        (pc_id),
    .hwlp_start_o   (hwlp_start),
    .hwlp_end_o     (hwlp_end),
    .hwlp_cnt_o     (hwlp_cnt),
    .hwlp_match_o   (hwlp_match),
    .hwlp_jump_o    (hwlp_jump),
    .hwlp_target_o  (hwlp_target)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_start[i] = '0;
      m_end[i]   = '0;
      m_cnt[i]   = '0;
    end
  endtask

  // Compare every output against what the model says for the current pc
  task automatic checkAll(input string tag);
    logic [N-1:0] e_match;
    logic         e_jump;
    logic [31:0]  e_target;
    e_match  = '0;
    e_jump   = 1'b0;
    e_target = '0;
    for (int i = 0; i < N; i++) begin
      e_match[i] = (pc_id == m_end[i]) && (m_cnt[i] != 0);
    end
    for (int i = 0; i < N; i++) begin
      if (!e_jump && e_match[i] && m_cnt[i] >= 2) begin
        e_jump   = 1'b1;
        e_target = m_start[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("%s start[%0d]", tag, i), hwlp_start[i], m_start[i]);
      checkOutput($sformatf("%s end[%0d]", tag, i),   hwlp_end[i],   m_end[i]);
      checkOutput($sformatf("%s cnt[%0d]", tag, i),   hwlp_cnt[i],   m_cnt[i]);
    end
    checkOutput({tag, " match"},  32'(hwlp_match), 32'(e_match));
    checkOutput({tag, " jump"},   32'(hwlp_jump),  32'(e_jump));
    checkOutput({tag, " target"}, hwlp_target,     e_target);
  endtask

  // Drive one cycle of inputs, update the model at the edge, then check
  task automatic applyStimulus(input string tag, input logic [2:0] we, input logic [NB-1:0] regid,
                               input logic [31:0] data, input logic [N-1:0] dec, input logic [31:0] pc);
    @(negedge clk);
    hwlp_we      = we;
    hwlp_regid   = regid;
    hwlp_data    = data;
    hwlp_dec_cnt = dec;
    pc_id        = pc;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (int'(regid) == i) begin
        if (we[0]) m_start[i] = data;
        if (we[1]) m_end[i]   = data;
      end
      if (we[2] && int'(regid) == i) m_cnt[i] = data;
      else if (dec[i] && m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
    end
    #1;
    hwlp_we      = '0;
    hwlp_dec_cnt = '0;
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [31:0] pool [4];
    logic [31:0] rdata;
    logic [31:0] rpc;
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    hwlp_we      = '0;
    hwlp_regid   = '0;
    hwlp_data    = '0;
    hwlp_dec_cnt = '0;
    pc_id        = 32'h1234;
    modelReset();

    // Reset state
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkAll("reset");
    pc_id = 32'h0;
    #1 checkAll("reset pc0");
    checkOutput("reset pc0 match0", 32'(hwlp_match[0]), 32'd0);

    // Write path, loop 1
    applyStimulus("wr start1", 3'b001, 2'd1, 32'h100, '0, 32'h0);
    checkOutput("wr start1 val", hwlp_start[1], 32'h100);
    applyStimulus("wr end1",   3'b010, 2'd1, 32'h120, '0, 32'h0);
    checkOutput("wr end1 val", hwlp_end[1], 32'h120);
    applyStimulus("wr cnt1",   3'b100, 2'd1, 32'd3,   '0, 32'h0);
    checkOutput("wr cnt1 val", hwlp_cnt[1], 32'd3);
    checkOutput("wr loop0 untouched", hwlp_cnt[0], 32'd0);

    // Out-of-range regid writes nothing
    applyStimulus("wr regid3", 3'b111, 2'd3, 32'hDEAD, '0, 32'h0);

    // Loop run on loop 0
    applyStimulus("run start0", 3'b001, 2'd0, 32'h40, '0, 32'h60);
    applyStimulus("run end0",   3'b010, 2'd0, 32'h60, '0, 32'h60);
    applyStimulus("run cnt0",   3'b100, 2'd0, 32'd2,  '0, 32'h60);
    checkOutput("run jump", 32'(hwlp_jump), 32'd1);
    checkOutput("run target", hwlp_target, 32'h40);
    applyStimulus("run dec1", 3'b000, 2'd0, 32'd0, 3'b001, 32'h60);
    checkOutput("run last match", 32'(hwlp_match[0]), 32'd1);
    checkOutput("run last jump", 32'(hwlp_jump), 32'd0);
    applyStimulus("run dec2", 3'b000, 2'd0, 32'd0, 3'b001, 32'h60);
    checkOutput("run done match", 32'(hwlp_match[0]), 32'd0);
    applyStimulus("run dec3", 3'b000, 2'd0, 32'd0, 3'b001, 32'h60);
    checkOutput("run saturate", hwlp_cnt[0], 32'd0);

    // Collision: a count write beats a decrement on the same loop only
    applyStimulus("col cnt0", 3'b100, 2'd0, 32'd5, '0, 32'h0);
    applyStimulus("col cnt1", 3'b100, 2'd1, 32'd4, '0, 32'h0);
    applyStimulus("col both", 3'b100, 2'd0, 32'd9, 3'b011, 32'h0);
    checkOutput("col cnt0 val", hwlp_cnt[0], 32'd9);
    checkOutput("col cnt1 val", hwlp_cnt[1], 32'd3);

    // Nesting priority
    applyStimulus("nest s0", 3'b001, 2'd0, 32'h10, '0, 32'h80);
    applyStimulus("nest s1", 3'b001, 2'd1, 32'h20, '0, 32'h80);
    applyStimulus("nest e0", 3'b010, 2'd0, 32'h80, '0, 32'h80);
    applyStimulus("nest e1", 3'b010, 2'd1, 32'h80, '0, 32'h80);
    applyStimulus("nest c0", 3'b100, 2'd0, 32'd3,  '0, 32'h80);
    applyStimulus("nest c1", 3'b100, 2'd1, 32'd7,  '0, 32'h80);
    checkOutput("nest target0", hwlp_target, 32'h10);
    applyStimulus("nest c0=1", 3'b100, 2'd0, 32'd1, '0, 32'h80);
    checkOutput("nest target1", hwlp_target, 32'h20);
    checkOutput("nest jump1", 32'(hwlp_jump), 32'd1);

    // Asynchronous reset between edges while a decrement is pending
    applyStimulus("ar cnt0", 3'b100, 2'd0, 32'd5, '0, 32'h80);
    @(negedge clk);
    hwlp_dec_cnt = 3'b001;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("async rst");
    checkOutput("async rst cnt0", hwlp_cnt[0], 32'd0);
    @(negedge clk);
    hwlp_dec_cnt = '0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkAll("after rst");

    // Randomised traffic
    pool[0] = 32'h40;
    pool[1] = 32'h60;
    pool[2] = 32'h80;
    pool[3] = 32'hFFFF_FFFC;
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 2))
        0: rdata = 32'($urandom_range(0, 4));
        1: rdata = pool[$urandom_range(0, 3)];
        default: rdata = $urandom;
      endcase
      rpc = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 3)] : $urandom;
      applyStimulus("rand",
                    ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
                    2'($urandom_range(0, 3)),
                    rdata,
                    3'($urandom),
                    rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
